fetch_unit: RTL and testbench

Parametrised instruction fetch front end: the next generation of the free-running `pc`/`pcnext` loop feeding `instructionDecoder`. It issues sequential fetch requests to an in-order memory port with arbitrary latency and buffers returned words in a DEPTH-entry prefetch FIFO. It presents words to the decoder with valid/ready handshaking and supports redirects (jumps) that flush the FIFO and discard in-flight responses.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch front end with a prefetch FIFO,
// bounded outstanding requests and redirect (jump) handling that flushes
// buffered words and discards responses still in flight.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int STEP_BYTES = DATA_W / 8;
  localparam int ALIGN_BITS = $clog2(STEP_BYTES);
  localparam int CNT_W      = $clog2(DEPTH + 1);
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int SUM_W      = CNT_W + 2;

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(STEP_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] rpc;
  logic              started;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];

  logic [SUM_W-1:0]  occupancy;
  logic              req_fire;
  logic              rsp_push;
  logic              rsp_drop;
  logic              pop;
  logic [ADDR_W-1:0] target_pc;
  logic [CNT_W:0]    stale_sum;
  logic [CNT_W:0]    stale_next;

  // Every live request owns a FIFO slot, so the issue budget counts buffered
  // words, returning words and words that will be thrown away.
  assign occupancy = SUM_W'(cnt) + SUM_W'(out_cnt) + SUM_W'(drop_cnt);
  assign req_valid = started && !redirect_valid && (occupancy < SUM_W'(DEPTH));
  assign req_addr  = fpc;
  assign req_fire  = req_valid && req_ready;

  assign rsp_drop  = rsp_valid && (drop_cnt != '0);
  assign rsp_push  = rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign instr_valid = (cnt != '0);
  assign instr_data  = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
  assign pop         = instr_valid && instr_ready;

  // A response landing in the redirect cycle is already stale, so it is
  // removed from the discard count it would otherwise have added to.
  assign target_pc  = redirect_pc & ALIGN_MASK;
  assign stale_sum  = (CNT_W+1)'(drop_cnt) + (CNT_W+1)'(out_cnt);
  assign stale_next = (rsp_valid && (stale_sum != '0)) ? stale_sum - (CNT_W+1)'(1) : stale_sum;

  // Control state: fetch/response address tracking, counters, FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      started  <= 1'b0;
      cnt      <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      started <= 1'b1;
      if (redirect_valid) begin
        fpc      <= target_pc;
        rpc      <= target_pc;
        cnt      <= '0;
        out_cnt  <= '0;
        drop_cnt <= CNT_W'(stale_next);
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) begin
          fpc <= fpc + STEP;
        end
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
        if (rsp_push) begin
          rpc    <= rpc + STEP;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        out_cnt <= out_cnt + CNT_W'(req_fire) - CNT_W'(rsp_push);
        cnt     <= cnt + CNT_W'(rsp_push) - CNT_W'(pop);
      end
    end
  end

  // FIFO storage: each accepted response is stored with the address it was fetched from.
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      fifo_data[wr_ptr] <= rsp_data;
      fifo_pc[wr_ptr]   <= rpc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-programmable
// in-order memory model that echoes the request address as the data word.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b1;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  int n_fire   = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t mq[$];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Memory model: captures handshakes just before each rising edge, returns
  // the echoed address mem_lat edges after acceptance, in order.
  initial begin
    int       cyc;
    logic     fire;
    logic     taken;
    mem_req_t entry;
    cyc = 0;
    forever begin
      @(negedge clk);
      #4;
      fire       = req_valid && req_ready;
      entry.addr = req_addr;
      taken      = rsp_valid;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        mq.delete();
      end else begin
        if (taken && mq.size() > 0) mq.delete(0);
        if (fire) begin
          entry.due = cyc + mem_lat - 1;
          mq.push_back(entry);
          n_fire++;
        end
      end
      if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = mq[0].addr;
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end
    end
  end

  // Hard stop in case a bounded wait is itself broken.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_req_valid"}, 32'(req_valid), 32'h0);
    check_value({tag, "_req_addr"}, req_addr, 32'h0);
    check_value({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    check_value({tag, "_instr_data"}, instr_data, 32'h0);
    check_value({tag, "_instr_pc"}, instr_pc, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_fire = 0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!instr_valid && n < budget) begin
      tick();
      n++;
    end
    check_value("wait_instr_valid", 32'(instr_valid), 32'h1);
  endtask

  task automatic expect_next(input logic [31:0] pc);
    wait_valid(30);
    check_value("next_pc", instr_pc, pc);
    check_value("next_data", instr_data, pc);
    tick();
  endtask

  task automatic stream_check(input string tag, input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      check_value({tag, "_valid"}, 32'(instr_valid), 32'h1);
      check_value({tag, "_pc"}, instr_pc, start + 32'(4 * i));
      check_value({tag, "_data"}, instr_data, start + 32'(4 * i));
      tick();
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    check_value("redirect_cycle_no_req", 32'(req_valid), 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  // Directed sequence of scenarios, each with hand-derived expectations.
  initial begin
    int n;

    // Reset values, then streaming with latency 1.
    mem_lat = 1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    check_value("first_req_valid", 32'(req_valid), 32'h1);
    check_value("first_req_addr", req_addr, 32'h0);
    tick();
    check_value("first_req_second_addr", req_addr, 32'h4);
    check_value("no_word_yet", 32'(instr_valid), 32'h0);
    tick();
    stream_check("stream_l1", 32'h0, 8);

    // Decoder stall: exactly four words buffered, issue stops, clean drain.
    instr_ready = 1'b0;
    do_reset();
    repeat (25) tick();
    check_value("stall_req_valid", 32'(req_valid), 32'h0);
    check_value("stall_fire_count", 32'(n_fire), 32'h4);
    check_value("stall_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    stream_check("drain", 32'h0, 8);

    // Redirect with three requests outstanding, latency 3.
    mem_lat = 3;
    do_reset();
    repeat (4) tick();
    check_value("pre_redirect_req_valid", 32'(req_valid), 32'h1);
    check_value("pre_redirect_req_addr", req_addr, 32'hC);
    do_redirect(32'h100);
    check_value("post_redirect_req_valid", 32'(req_valid), 32'h1);
    check_value("post_redirect_req_addr", req_addr, 32'h100);
    check_value("post_redirect_empty", 32'(instr_valid), 32'h0);
    expect_next(32'h100);
    expect_next(32'h104);
    expect_next(32'h108);
    expect_next(32'h10C);

    // Redirect coincident with a response and an output handshake.
    n = 0;
    while (!(rsp_valid && instr_valid) && n < 20) begin
      tick();
      n++;
    end
    check_value("coincident_head_valid", 32'(instr_valid), 32'h1);
    do_redirect(32'h200);
    check_value("coincident_flush_empty", 32'(instr_valid), 32'h0);
    check_value("coincident_req_addr", req_addr, 32'h200);
    expect_next(32'h200);
    expect_next(32'h204);
    expect_next(32'h208);

    // Redirect alignment and address wrap.
    mem_lat = 1;
    do_reset();
    repeat (4) tick();
    do_redirect(32'h103);
    check_value("aligned_req_valid", 32'(req_valid), 32'h1);
    check_value("aligned_req_addr", req_addr, 32'h100);
    expect_next(32'h100);
    expect_next(32'h104);
    do_redirect(32'hFFFF_FFFE);
    check_value("wrap_req_addr_top", req_addr, 32'hFFFF_FFFC);
    tick();
    check_value("wrap_req_addr_zero", req_addr, 32'h0);
    expect_next(32'hFFFF_FFFC);
    expect_next(32'h0);
    expect_next(32'h4);

    // Asynchronous reset mid-stream with buffered and in-flight words.
    mem_lat = 3;
    instr_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    check_value("pre_reset_buffered", 32'(instr_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    tick();
    check_value("restart_req_valid", 32'(req_valid), 32'h1);
    check_value("restart_req_addr", req_addr, 32'h0);
    expect_next(32'h0);
    expect_next(32'h4);
    expect_next(32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
